clarvi_data_mem_responder: RTL and testbench

- Responder end of the core's data memory port.
- Accepts word-addressed read and write requests with byte enables from the load/store unit, backed by an on-chip 32-bit word array.
- Returns read data through a fixed-latency pipeline with a valid strobe, so the core's pending-read tracking can match each reply to its request.
- Flags out-of-range accesses instead of aliasing them into memory.

---
 rtl/clarvi_data_mem_responder_if.sv | 31 +++
 rtl/clarvi_data_mem_responder.sv | 87 ++++++++
 tb/tb_clarvi_data_mem_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/clarvi_data_mem_responder_if.sv
// Data memory port between the core's load/store unit (master) and the
// on-chip responder (slave).
interface clarvi_data_mem_responder_if #(
    parameter int DATA_ADDR_WIDTH = 14,
    parameter int HIGH_BITS_WIDTH = 48
);
    logic [HIGH_BITS_WIDTH-1:0] address_high_bits;
    logic [DATA_ADDR_WIDTH-1:0] main_address;
    logic [3:0]                 main_byte_enable;
    logic                       main_read_enable;
    logic                       main_write_enable;
    logic [31:0]                main_write_data;
    logic [31:0]                main_read_data;
    logic                       main_read_data_valid;
    logic                       main_access_error;
    logic [2:0]                 reads_outstanding;

    modport master (
        output address_high_bits, main_address, main_byte_enable,
               main_read_enable, main_write_enable, main_write_data,
        input  main_read_data, main_read_data_valid, main_access_error,
               reads_outstanding
    );

    modport slave (
        input  address_high_bits, main_address, main_byte_enable,
               main_read_enable, main_write_enable, main_write_data,
        output main_read_data, main_read_data_valid, main_access_error,
               reads_outstanding
    );
endinterface

// File: rtl/clarvi_data_mem_responder.sv
// Word-addressed data memory with byte-enable writes, a fixed-latency read
// reply pipeline and out-of-range / illegal-request error reporting.
module clarvi_data_mem_responder #(
    parameter int DATA_ADDR_WIDTH = 14,
    parameter int READ_LATENCY    = 1,
    parameter int HIGH_BITS_WIDTH = 48
) (
    input logic                        clock,
    input logic                        reset,
    clarvi_data_mem_responder_if.slave bus
);
    localparam int unsigned LAST = READ_LATENCY - 1;

    logic [31:0] mem [2**DATA_ADDR_WIDTH];

    logic [HIGH_BITS_WIDTH-1:0] high_bits;
    logic out_of_range;
    logic read_hit;
    logic do_write;
    logic slot_valid;
    logic slot_error;

    assign high_bits = bus.address_high_bits;

    always_comb begin
        out_of_range = |high_bits;
        read_hit     = bus.main_read_enable && !bus.main_write_enable && !out_of_range;
        do_write     = bus.main_write_enable && !bus.main_read_enable && !out_of_range && !reset;
        // Any read (including illegal read+write) owns a valid reply slot.
        slot_valid   = bus.main_read_enable;
        slot_error   = (bus.main_read_enable && bus.main_write_enable) ||
                       (out_of_range && (bus.main_read_enable || bus.main_write_enable));
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.main_byte_enable[i])
                    mem[bus.main_address][8*i +: 8] <= bus.main_write_data[8*i +: 8];
            end
        end
    end

    logic [LAST:0] stage_valid;
    logic [LAST:0] stage_error;
    logic [31:0]   stage_data [READ_LATENCY];
    logic [2:0]    outstanding;

    // Only the final stage holds its data across empty slots; earlier stages
    // may capture freely since their data is qualified by the valid bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_valid <= '0;
            stage_error <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++)
                stage_data[i] <= '0;
        end else begin
            stage_valid[0] <= slot_valid;
            stage_error[0] <= slot_error;
            if (slot_valid || LAST != 0)
                stage_data[0] <= read_hit ? mem[bus.main_address] : '0;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_error[i] <= stage_error[i-1];
                if (stage_valid[i-1] || i < LAST)
                    stage_data[i] <= stage_data[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({slot_valid, stage_valid[LAST]})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign bus.main_read_data       = stage_data[LAST];
    assign bus.main_read_data_valid = stage_valid[LAST];
    assign bus.main_access_error    = stage_error[LAST];
    assign bus.reads_outstanding    = outstanding;
endmodule

// File: tb/tb_clarvi_data_mem_responder.sv
// Drives three responders (read latency 1, 2, 3) with identical traffic and
// checks each against a reply-schedule model of the data memory port.
module tb_clarvi_data_mem_responder;
    localparam int AW   = 6;
    localparam int HW   = 62 - AW;
    localparam int NLAT = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [HW-1:0] hb    = '0;
    logic [AW-1:0] addr  = '0;
    logic [3:0]    be    = '0;
    logic          rd    = 1'b0;
    logic          wr    = 1'b0;
    logic [31:0]   wd    = '0;

    logic [31:0] rdata  [NLAT];
    logic        rvalid [NLAT];
    logic        rerr   [NLAT];
    logic [2:0]  outst  [NLAT];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NLAT; g++) begin : lane
        clarvi_data_mem_responder_if #(.DATA_ADDR_WIDTH(AW), .HIGH_BITS_WIDTH(HW)) bif ();
        clarvi_data_mem_responder #(
            .DATA_ADDR_WIDTH(AW),
            .READ_LATENCY(g + 1),
            .HIGH_BITS_WIDTH(HW)
        ) dut (
            .clock(clock),
            .reset(reset),
            .bus(bif.slave)
        );
        assign bif.address_high_bits = hb;
        assign bif.main_address      = addr;
        assign bif.main_byte_enable  = be;
        assign bif.main_read_enable  = rd;
        assign bif.main_write_enable = wr;
        assign bif.main_write_data   = wd;
        assign rdata[g]  = bif.main_read_data;
        assign rvalid[g] = bif.main_read_data_valid;
        assign rerr[g]   = bif.main_access_error;
        assign outst[g]  = bif.reads_outstanding;
    end

    // Model: every accepted request that owns a reply slot is recorded with
    // the edge number that accepted it; a latency-L responder shows it after
    // edge acc+L-1.
    typedef struct {
        int          acc;
        bit          v;
        bit          e;
        logic [31:0] d;
    } slot_t;

    slot_t       q [$];
    logic [31:0] mem_m  [2**AW];
    logic [31:0] last_d [NLAT];
    int          cur    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          armed  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, cur);
        end
    endtask

    function automatic void accept();
        slot_t       s;
        logic [31:0] m;
        cur++;
        while (q.size() > 0 && q[0].acc < cur - NLAT) void'(q.pop_front());
        if (reset) begin
            q.delete();
            foreach (last_d[k]) last_d[k] = '0;
            armed = 1'b1;
            return;
        end
        s.acc = cur;
        s.v   = rd;
        s.e   = (rd && wr) || (hb != '0 && (rd || wr));
        s.d   = (rd && !wr && hb == '0) ? mem_m[addr] : 32'h0;
        if (rd || (wr && hb != '0)) q.push_back(s);
        if (wr && !rd && hb == '0) begin
            m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            mem_m[addr] = (mem_m[addr] & ~m) | (wd & m);
        end
    endfunction

    task automatic drive(input logic [HW-1:0] h, input logic [AW-1:0] a, input logic [3:0] b,
                         input logic r, input logic w, input logic [31:0] d, input logic x);
        @(negedge clock);
        hb = h; addr = a; be = b; rd = r; wr = w; wd = d; reset = x;
        @(posedge clock);
        accept();
    endtask

    task automatic idle();
        drive('0, '0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d);
        drive('0, a, b, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic read(input logic [AW-1:0] a);
        drive('0, a, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    // Per-cycle comparison of every responder against the model.
    always @(negedge clock) begin
        if (armed) begin
            for (int k = 0; k < NLAT; k++) begin
                bit ev;
                bit ee;
                int n;
                ev = 1'b0;
                ee = 1'b0;
                n  = 0;
                foreach (q[j]) begin
                    if (q[j].acc + k == cur) begin
                        ev = q[j].v;
                        ee = q[j].e;
                        if (q[j].v) last_d[k] = q[j].d;
                    end
                    if (q[j].v && q[j].acc <= cur && q[j].acc >= cur - k) n++;
                end
                check($sformatf("L%0d valid", k + 1), {31'h0, rvalid[k]}, {31'h0, ev});
                check($sformatf("L%0d error", k + 1), {31'h0, rerr[k]}, {31'h0, ee});
                check($sformatf("L%0d data", k + 1), rdata[k], last_d[k]);
                check($sformatf("L%0d outstanding", k + 1), {29'h0, outst[k]}, 32'(n));
            end
        end
    end

    initial begin
        repeat (3) drive('0, '0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        for (int k = 0; k < NLAT; k++) begin
            check("reset data", rdata[k], 32'h0);
            check("reset valid", {31'h0, rvalid[k]}, 32'h0);
            check("reset error", {31'h0, rerr[k]}, 32'h0);
            check("reset outstanding", {29'h0, outst[k]}, 32'h0);
        end

        for (int i = 0; i < 2**AW; i++) write(AW'(i), 4'hF, $urandom);

        write(6'h10, 4'hF, 32'hDEADBEEF);
        read(6'h10);
        #1;
        check("full word read", rdata[0], 32'hDEADBEEF);
        check("full word valid", {31'h0, rvalid[0]}, 32'h1);
        check("full word error", {31'h0, rerr[0]}, 32'h0);

        write(6'h20, 4'hF, 32'h11223344);
        write(6'h20, 4'b0100, 32'h00AA0000);
        read(6'h20);
        #1 check("byte lane merge", rdata[0], 32'h11AA3344);
        write(6'h20, 4'b0000, 32'hFFFFFFFF);
        read(6'h20);
        #1 check("empty byte enable", rdata[0], 32'h11AA3344);

        idle(); idle(); idle();
        write(6'h01, 4'hF, 32'hA1A1A1A1);
        write(6'h02, 4'hF, 32'hA2A2A2A2);
        write(6'h03, 4'hF, 32'hA3A3A3A3);
        read(6'h01); read(6'h02); read(6'h03);
        #1;
        check("L3 peak outstanding", {29'h0, outst[2]}, 32'd3);
        check("L3 first reply", rdata[2], 32'hA1A1A1A1);
        idle();
        #1 check("L3 second reply", rdata[2], 32'hA2A2A2A2);
        idle();
        #1 check("L3 third reply", rdata[2], 32'hA3A3A3A3);
        idle();
        #1 check("L3 drained", {29'h0, outst[2]}, 32'd0);

        drive(HW'(1), 6'h07, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        check("oor read valid", {31'h0, rvalid[0]}, 32'h1);
        check("oor read data", rdata[0], 32'h0);
        check("oor read error", {31'h0, rerr[0]}, 32'h1);

        write(6'h05, 4'hF, 32'hCAFEF00D);
        drive(HW'(1), 6'h05, 4'hF, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b0);
        #1;
        check("oor write error", {31'h0, rerr[0]}, 32'h1);
        check("oor write valid", {31'h0, rvalid[0]}, 32'h0);
        read(6'h05);
        #1 check("oor write suppressed", rdata[0], 32'hCAFEF00D);

        write(6'h30, 4'hF, 32'h12345678);
        drive('0, 6'h30, 4'hF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        #1;
        check("illegal valid", {31'h0, rvalid[0]}, 32'h1);
        check("illegal error", {31'h0, rerr[0]}, 32'h1);
        check("illegal data", rdata[0], 32'h0);
        read(6'h30);
        #1 check("illegal no write", rdata[0], 32'h12345678);

        idle(); idle(); idle();
        read(6'h30);
        drive('0, '0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("L2 reset valid", {31'h0, rvalid[1]}, 32'h0);
        check("L2 reset outstanding", {29'h0, outst[1]}, 32'h0);
        check("L2 reset data", rdata[1], 32'h0);
        repeat (3) begin
            idle();
            #1 check("L2 no late valid", {31'h0, rvalid[1]}, 32'h0);
        end

        for (int n = 0; n < 2000; n++) begin
            logic [HW-1:0] h;
            int            op;
            h  = ($urandom_range(0, 9) == 0) ? (HW'(1) << $urandom_range(0, HW - 1)) : '0;
            op = $urandom_range(0, 9);
            drive(h, AW'($urandom), 4'($urandom), op <= 3 || op == 7, op >= 4 && op <= 7,
                  $urandom, $urandom_range(0, 99) < 2);
        end
        repeat (5) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
